// File: rtl/output_writeback.sv
// Output writeback stage: bias, optional ReLU and saturation of convolution
// results, buffered in a small FIFO and written to sequential buffer addresses.
module output_writeback #(
  parameter int DataWidth = 32,
  parameter int OutWidth  = 16,
  parameter int AddrWidth = 10,
  parameter int FifoDepth = 4
) (
  input  logic                 clk,
  input  logic                 aclr,
  input  logic                 start,
  input  logic [AddrWidth-1:0] frame_len,
  input  logic [AddrWidth-1:0] base_addr,
  input  logic [DataWidth-1:0] bias,
  input  logic                 relu_en,
  input  logic                 in_valid,
  input  logic [DataWidth-1:0] in_data,
  output logic                 wr_valid,
  input  logic                 wr_ready,
  output logic [AddrWidth-1:0] wr_addr,
  output logic [OutWidth-1:0]  wr_data,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow
);

  localparam int PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam logic signed [DataWidth:0] SatMax =
    {{(DataWidth-OutWidth+2){1'b0}}, {(OutWidth-1){1'b1}}};
  localparam logic signed [DataWidth:0] SatMin =
    {{(DataWidth-OutWidth+2){1'b1}}, {(OutWidth-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state_r, state_next_s;

  logic [AddrWidth-1:0] frame_len_r;
  logic [AddrWidth-1:0] base_r;
  logic [DataWidth-1:0] bias_r;
  logic                 relu_r;
  logic [AddrWidth-1:0] in_cnt_r;
  logic [AddrWidth-1:0] out_cnt_r;
  logic                 overflow_r;

  logic [OutWidth-1:0]  mem_r [FifoDepth];
  logic [PtrW-1:0]      wr_ptr_r;
  logic [PtrW-1:0]      rd_ptr_r;
  logic [PtrW:0]        count_r;

  logic                 start_ok_s;
  logic                 accept_s;
  logic                 empty_s;
  logic                 full_s;
  logic                 pop_s;
  logic                 push_s;
  logic                 drop_s;
  logic                 last_in_s;
  logic [OutWidth-1:0]  proc_s;

  // Sum is one bit wider than the operands so bias addition can never wrap.
  function automatic logic [OutWidth-1:0] bias_relu_sat(
    input logic [DataWidth-1:0] d,
    input logic [DataWidth-1:0] b,
    input logic                 relu
  );
    logic signed [DataWidth:0] s;
    s = {d[DataWidth-1], d} + {b[DataWidth-1], b};
    if (relu && s[DataWidth]) begin
      s = '0;
    end
    if (s > SatMax) begin
      return SatMax[OutWidth-1:0];
    end else if (s < SatMin) begin
      return SatMin[OutWidth-1:0];
    end else begin
      return s[OutWidth-1:0];
    end
  endfunction

  assign start_ok_s = (state_r == IDLE) && start;
  assign accept_s   = (state_r == RUN) && in_valid;
  assign empty_s    = (count_r == '0);
  assign full_s     = (count_r == (PtrW+1)'(FifoDepth));
  assign pop_s      = !empty_s && wr_ready;
  assign push_s     = accept_s && (!full_s || pop_s);
  assign drop_s     = accept_s && full_s && !pop_s;
  assign last_in_s  = accept_s && ((in_cnt_r + AddrWidth'(1)) == frame_len_r);
  assign proc_s     = bias_relu_sat(in_data, bias_r, relu_r);

  // State register.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; DRAIN leaves on the edge that pops the last entry.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next_s = (frame_len == '0) ? DONE : RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if (last_in_s) begin
          state_next_s = DRAIN;
        end else begin
          state_next_s = RUN;
        end
      end
      DRAIN: begin
        if (empty_s || ((count_r == (PtrW+1)'(1)) && pop_s)) begin
          state_next_s = DONE;
        end else begin
          state_next_s = DRAIN;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Frame parameters, counters and the sticky overflow flag.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      frame_len_r <= '0;
      base_r      <= '0;
      bias_r      <= '0;
      relu_r      <= 1'b0;
      in_cnt_r    <= '0;
      out_cnt_r   <= '0;
      overflow_r  <= 1'b0;
    end else if (start_ok_s) begin
      frame_len_r <= frame_len;
      base_r      <= base_addr;
      bias_r      <= bias;
      relu_r      <= relu_en;
      in_cnt_r    <= '0;
      out_cnt_r   <= '0;
      overflow_r  <= 1'b0;
    end else begin
      if (accept_s) begin
        in_cnt_r <= in_cnt_r + AddrWidth'(1);
      end
      if (pop_s) begin
        out_cnt_r <= out_cnt_r + AddrWidth'(1);
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PtrW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PtrW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (PtrW+1)'(1);
        2'b01:   count_r <= count_r - (PtrW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // FIFO storage; contents are don't-care while empty since wr_data is masked.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= proc_s;
    end
  end

  assign wr_valid = !empty_s;
  assign wr_data  = empty_s ? '0 : mem_r[rd_ptr_r];
  assign wr_addr  = base_r + out_cnt_r;
  assign busy     = (state_r != IDLE);
  assign done     = (state_r == DONE);
  assign overflow = overflow_r;

endmodule

// File: tb/tb_output_writeback.sv
// Scoreboard bench for output_writeback: expected writes are queued when
// stimulus is driven and compared by a monitor when the buffer accepts them.
module tb_output_writeback;
  localparam int DW = 32;
  localparam int OW = 16;
  localparam int AW = 10;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          aclr = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] frame_len = '0;
  logic [AW-1:0] base_addr = '0;
  logic [DW-1:0] bias = '0;
  logic          relu_en = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          wr_ready = 1'b0;
  logic          wr_valid;
  logic [AW-1:0] wr_addr;
  logic [OW-1:0] wr_data;
  logic          busy;
  logic          done;
  logic          overflow;

  logic [AW+OW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_fail = 0;

  output_writeback #(.DataWidth(DW), .OutWidth(OW), .AddrWidth(AW), .FifoDepth(FD)) dut (
    .clk(clk), .aclr(aclr), .start(start), .frame_len(frame_len),
    .base_addr(base_addr), .bias(bias), .relu_en(relu_en),
    .in_valid(in_valid), .in_data(in_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Scoreboard: every completed write must match the oldest expectation.
  always @(negedge clk) begin
    if (!aclr && wr_valid && wr_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got addr=%0d data=%0d, required no write",
                 wr_addr, $signed(wr_data));
      end else begin
        logic [AW+OW-1:0] e;
        e = exp_q.pop_front();
        if ({wr_addr, wr_data} !== e) begin
          n_fail++;
          $display("FAIL write: got addr=%0d data=%0d, required addr=%0d data=%0d",
                   wr_addr, $signed(wr_data), e[AW+OW-1:OW], $signed(e[OW-1:0]));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input int addr, input int data);
    exp_q.push_back({AW'(addr), OW'(data)});
  endtask

  // Parameters are scrambled after the start edge to prove they were captured.
  task automatic do_start(input int len, input int base, input int b, input bit relu);
    frame_len = AW'(len);
    base_addr = AW'(base);
    bias      = DW'(b);
    relu_en   = relu;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    frame_len = AW'(7);
    base_addr = AW'(555);
    bias      = DW'(12345);
    relu_en   = ~relu;
  endtask

  task automatic send(input int d);
    in_valid = 1'b1;
    in_data  = DW'(d);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int pulses, output bit finished);
    pulses = 0;
    finished = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (done) pulses++;
      if (!busy) begin
        finished = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if ({wr_valid, busy, done, overflow} !== 4'b0000 || wr_addr !== '0 || wr_data !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got valid/busy/done/ovf=%b addr=%0d data=%0d, required 0000/0/0",
               {wr_valid, busy, done, overflow}, wr_addr, wr_data);
    end
    tick();
    aclr = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int p; bit f;
    wr_ready = 1'b1;
    do_start(3, 100, 5, 1'b0);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL basic_busy: got %b, required 1", busy);
    end
    expect_wr(100, 6); expect_wr(101, 7); expect_wr(102, 8);
    send(1);
    n_cmp++;
    if (wr_valid !== 1'b1) begin
      n_fail++; $display("FAIL basic_latency: got wr_valid=%b, required 1", wr_valid);
    end
    send(2); send(3);
    wait_done(p, f);
    n_cmp++;
    if (p !== 1 || !f) begin
      n_fail++; $display("FAIL basic_done: got pulses=%0d idle=%0d, required 1/1", p, f);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL basic_drained: got %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_arith();
    int p; bit f;
    wr_ready = 1'b1;
    do_start(3, 0, 0, 1'b1);
    expect_wr(0, 32767); expect_wr(1, 0); expect_wr(2, 0);
    send(40000); send(-40000); send(-7);
    wait_done(p, f);
    do_start(3, 10, 0, 1'b0);
    expect_wr(10, 32767); expect_wr(11, -32768); expect_wr(12, -7);
    send(40000); send(-40000); send(-7);
    wait_done(p, f);
    // Extreme operands: the sum must not wrap at DataWidth bits.
    do_start(2, 20, 2147483647, 1'b0);
    expect_wr(20, 32767); expect_wr(21, -1);
    send(2147483647); send(int'(32'h8000_0000));
    wait_done(p, f);
    n_cmp++;
    if (p !== 1 || !f || exp_q.size() != 0) begin
      n_fail++; $display("FAIL arith_done: got pulses=%0d idle=%0d pending=%0d, required 1/1/0",
                         p, f, exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    int p; bit f;
    wr_ready = 1'b0;
    do_start(6, 200, 0, 1'b0);
    for (int i = 0; i < 4; i++) expect_wr(200 + i, 10 + i);
    for (int i = 0; i < 6; i++) send(10 + i);
    n_cmp++;
    if (overflow !== 1'b1 || wr_valid !== 1'b1) begin
      n_fail++; $display("FAIL bp_overflow: got ovf=%b valid=%b, required 1/1", overflow, wr_valid);
    end
    tick(); tick(); tick();
    n_cmp++;
    if (wr_addr !== AW'(200) || wr_data !== OW'(10) || busy !== 1'b1 || done !== 1'b0) begin
      n_fail++; $display("FAIL bp_hold: got addr=%0d data=%0d busy=%b done=%b, required 200/10/1/0",
                         wr_addr, wr_data, busy, done);
    end
    wr_ready = 1'b1;
    wait_done(p, f);
    n_cmp++;
    if (p !== 1 || !f || exp_q.size() != 0) begin
      n_fail++; $display("FAIL bp_done: got pulses=%0d idle=%0d pending=%0d, required 1/1/0",
                         p, f, exp_q.size());
    end
    n_cmp++;
    if (overflow !== 1'b1) begin
      n_fail++; $display("FAIL bp_sticky: got %b, required 1", overflow);
    end
  endtask

  task automatic test_wrap_zero();
    int p; bit f;
    wr_ready = 1'b1;
    do_start(4, 1022, 0, 1'b0);
    n_cmp++;
    if (overflow !== 1'b0) begin
      n_fail++; $display("FAIL start_clears_ovf: got %b, required 0", overflow);
    end
    expect_wr(1022, 1); expect_wr(1023, 2); expect_wr(0, 3); expect_wr(1, 4);
    send(1); send(2); send(3); send(4);
    wait_done(p, f);
    n_cmp++;
    if (p !== 1 || !f || exp_q.size() != 0) begin
      n_fail++; $display("FAIL wrap_done: got pulses=%0d idle=%0d pending=%0d, required 1/1/0",
                         p, f, exp_q.size());
    end
    do_start(0, 5, 0, 1'b0);
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL zero_len_done: got done=%b busy=%b, required 1/1", done, busy);
    end
    tick();
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0 || wr_valid !== 1'b0) begin
      n_fail++; $display("FAIL zero_len_end: got done=%b busy=%b valid=%b, required 0/0/0",
                         done, busy, wr_valid);
    end
  endtask

  task automatic test_reset_mid();
    int p; bit f;
    wr_ready = 1'b1;
    do_start(5, 300, 0, 1'b0);
    expect_wr(300, 1);
    in_valid = 1'b1; in_data = DW'(1);
    tick();
    in_data = DW'(2);
    tick();
    in_valid = 1'b0; wr_ready = 1'b0;
    n_cmp++;
    if (wr_valid !== 1'b1) begin
      n_fail++; $display("FAIL mid_pending: got wr_valid=%b, required 1", wr_valid);
    end
    aclr = 1'b1;
    #2;
    n_cmp++;
    if ({wr_valid, busy, done, overflow} !== 4'b0000 || wr_addr !== '0 || wr_data !== '0) begin
      n_fail++; $display("FAIL mid_reset: got valid/busy/done/ovf=%b addr=%0d data=%0d, required 0000/0/0",
                         {wr_valid, busy, done, overflow}, wr_addr, wr_data);
    end
    tick();
    aclr = 1'b0;
    wr_ready = 1'b1;
    do_start(2, 40, 1, 1'b0);
    n_cmp++;
    if (overflow !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL mid_restart: got ovf=%b busy=%b, required 0/1", overflow, busy);
    end
    expect_wr(40, 8); expect_wr(41, 9);
    send(7); send(8);
    wait_done(p, f);
    n_cmp++;
    if (p !== 1 || !f || exp_q.size() != 0) begin
      n_fail++; $display("FAIL mid_done: got pulses=%0d idle=%0d pending=%0d, required 1/1/0",
                         p, f, exp_q.size());
    end
  endtask

  task automatic test_ignored();
    int p; bit f;
    wr_ready = 1'b0;
    in_valid = 1'b1; in_data = DW'(55);
    tick(); tick();
    in_valid = 1'b0;
    n_cmp++;
    if (wr_valid !== 1'b0 || overflow !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL idle_ignore: got valid=%b ovf=%b busy=%b, required 0/0/0",
                         wr_valid, overflow, busy);
    end
    do_start(4, 500, 10, 1'b0);
    for (int i = 0; i < 4; i++) expect_wr(500 + i, 11 + i);
    send(1);
    frame_len = AW'(7); base_addr = AW'(600); bias = DW'(1000); start = 1'b1;
    send(2);
    start = 1'b0;
    send(3); send(4);
    in_valid = 1'b1; in_data = DW'(77);
    tick(); tick();
    in_valid = 1'b0;
    n_cmp++;
    if (overflow !== 1'b0 || busy !== 1'b1 || wr_addr !== AW'(500) || wr_data !== OW'(11)) begin
      n_fail++; $display("FAIL drain_ignore: got ovf=%b busy=%b addr=%0d data=%0d, required 0/1/500/11",
                         overflow, busy, wr_addr, wr_data);
    end
    wr_ready = 1'b1;
    wait_done(p, f);
    n_cmp++;
    if (p !== 1 || !f || exp_q.size() != 0) begin
      n_fail++; $display("FAIL ignore_done: got pulses=%0d idle=%0d pending=%0d, required 1/1/0",
                         p, f, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_arith();
    test_backpressure();
    test_wrap_zero();
    test_reset_mid();
    test_ignored();
    tick(); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
